// File: rtl/note_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : note_scheduler
//  Purpose  : Walks a song's note list in a synchronous ROM and issues one
//             load_new_note pulse per entry, holding each note for its beats.
//  Revision : 1.0  initial release
// ============================================================================
module note_scheduler #(
  parameter int INDEX_WIDTH = 5,
  parameter int SONG_WIDTH  = 2,
  parameter int DUR_WIDTH   = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              play_enable,
  input  logic                              beat,
  input  logic [SONG_WIDTH-1:0]             song_select,
  output logic [SONG_WIDTH+INDEX_WIDTH-1:0] rom_addr,
  input  logic [15:0]                       rom_data,
  output logic [5:0]                        note_to_load,
  output logic [1:0]                        weight,
  output logic                              load_new_note,
  output logic                              song_done
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_WAIT_ROM = 3'd2,
    ST_LOAD     = 3'd3,
    ST_PLAY     = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam logic [INDEX_WIDTH-1:0] c_LAST_INDEX = {INDEX_WIDTH{1'b1}};
  localparam logic [INDEX_WIDTH-1:0] c_INDEX_ONE  = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [DUR_WIDTH-1:0]   c_DUR_ONE    = {{(DUR_WIDTH-1){1'b0}}, 1'b1};

  state_t                 r_state;
  logic [INDEX_WIDTH-1:0] r_index;
  logic [DUR_WIDTH-1:0]   r_remaining;
  logic [SONG_WIDTH-1:0]  r_song_prev;

  logic                   w_song_change;
  logic [DUR_WIDTH-1:0]   w_duration;
  logic                   w_unused_rsvd;

  assign w_song_change = (song_select != r_song_prev);
  assign w_duration    = rom_data[4 +: DUR_WIDTH];
  assign w_unused_rsvd = ^rom_data[1:0];

  // rom_addr is loaded on the transition into FETCH so the ROM sees it during
  // FETCH and its data is ready in WAIT_ROM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= ST_IDLE;
      r_index       <= '0;
      r_remaining   <= '0;
      r_song_prev   <= '0;
      rom_addr      <= '0;
      note_to_load  <= '0;
      weight        <= '0;
      load_new_note <= 1'b0;
      song_done     <= 1'b0;
    end else begin
      r_song_prev   <= song_select;
      load_new_note <= 1'b0;
      if (w_song_change) begin
        r_index   <= '0;
        song_done <= 1'b0;
        if (play_enable) begin
          rom_addr <= {song_select, {INDEX_WIDTH{1'b0}}};
          r_state  <= ST_FETCH;
        end else begin
          r_state  <= ST_IDLE;
        end
      end else if (play_enable) begin
        case (r_state)
          ST_IDLE: begin
            rom_addr <= {song_select, r_index};
            r_state  <= ST_FETCH;
          end
          ST_FETCH: r_state <= ST_WAIT_ROM;
          ST_WAIT_ROM: begin
            if (w_duration == '0) begin
              song_done <= 1'b1;
              r_state   <= ST_DONE;
            end else begin
              r_remaining   <= w_duration;
              note_to_load  <= rom_data[15:10];
              weight        <= rom_data[3:2];
              load_new_note <= 1'b1;
              r_state       <= ST_LOAD;
            end
          end
          ST_LOAD: r_state <= ST_PLAY;
          ST_PLAY: begin
            if (beat) begin
              if (r_remaining == c_DUR_ONE) begin
                if (r_index == c_LAST_INDEX) begin
                  song_done <= 1'b1;
                  r_state   <= ST_DONE;
                end else begin
                  r_index  <= r_index + c_INDEX_ONE;
                  rom_addr <= {song_select, r_index + c_INDEX_ONE};
                  r_state  <= ST_FETCH;
                end
              end else begin
                r_remaining <= r_remaining - c_DUR_ONE;
              end
            end
          end
          ST_DONE: r_state <= ST_DONE;
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/note_scheduler.md
Name: note_scheduler

Overview:
- Upstream stage of note_player: walks a per-song note list in an external synchronous song ROM and issues one load_new_note pulse per entry, with note_to_load and weight.
- Holds each note for its duration, counted in beat pulses from beat_generator (48 beats per whole note).
- Freezes while play_enable is low; raises song_done at the end marker or when the song's address space runs out.

Parameters:
- INDEX_WIDTH, 5: entry index bits per song; 32 entries per song.
- SONG_WIDTH, 2: song_select bits; 4 songs.
- DUR_WIDTH, 6: duration field width, in beats.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play_enable  in  1  high = advance; low = pause (hold all state)
- beat  in  1  one-cycle pulse from beat_generator
- song_select  in  SONG_WIDTH  active song; a change restarts the song
- rom_addr  out  SONG_WIDTH+INDEX_WIDTH  {song_select, index}, registered
- rom_data  in  16  entry at rom_addr, valid 1 cycle after rom_addr: [15:10] note (0 = rest), [9:4] duration, [3:2] weight, [1:0] reserved
- note_to_load  out  6  note for note_player, registered
- weight  out  2  harmonic weight for note_player, registered
- load_new_note  out  1  one-cycle pulse; note_to_load and weight are valid on the same cycle
- song_done  out  1  level; high in DONE

Behaviour:
- Reset (async) values: state IDLE, index 0, rom_addr 0, note_to_load 0, weight 0, load_new_note 0, song_done 0, beat counter 0.
- IDLE:
  - Go to FETCH when play_enable = 1.
- FETCH:
  - rom_addr = {song_select, index}.
  - Next cycle: WAIT_ROM.
- WAIT_ROM:
  - Capture rom_data.
  - If duration field = 0 (end marker): go to DONE.
  - Otherwise: remaining = duration, go to LOAD.
- LOAD:
  - Drive load_new_note = 1 for exactly one cycle, with registered note_to_load and weight.
  - Rest entries (note 0) still pulse with note 0.
  - Next cycle: PLAY.
- PLAY:
  - Each cycle with beat & play_enable: remaining -= 1.
  - When remaining = 1 and beat & play_enable on the same cycle:
    - If index = 2^INDEX_WIDTH-1: go to DONE.
    - Otherwise: index += 1, go to FETCH.
  - A beat in FETCH, WAIT_ROM or LOAD is ignored and not counted.
- DONE:
  - song_done = 1.
  - Leave only on a song_select change or reset.
- Latency:
  - FETCH entry to load_new_note pulse: 2 cycles.
  - Final beat of a note to the next note's pulse: 3 cycles.
- Pause (play_enable = 0):
  - FSM and counters hold in every state.
  - No load_new_note is issued; a pending LOAD pulse waits until play_enable returns.
  - rom_addr holds.
- song_select change:
  - Detected by comparing against a registered copy; takes priority over all other transitions, including DONE.
  - Effect: index = 0, song_done = 0, load_new_note = 0, go to FETCH on the next cycle if play_enable = 1, else IDLE.
- Index wrap: index never wraps silently. Overflow past the last entry ends in DONE.
- Duration arithmetic: unsigned DUR_WIDTH bits; remaining never underflows because duration 0 never enters PLAY.
- Outputs note_to_load and weight hold their last loaded values between pulses and in DONE.

Test Plan:
- Reset then play_enable = 1, song 0, ROM[0] = {note 22, dur 3, wt 1}, ROM[1] = dur 0 -> rom_addr 0; load_new_note pulses 2 cycles after FETCH with note 22, weight 1; after 3 beats, FETCH of addr 1; song_done = 1, note_to_load stays 22.
- Two entries with durations 1 and 2, beat every 5 cycles -> exactly two load pulses, 3 cycles after the counted beat; pulse count = 2 over 200 cycles.
- play_enable dropped mid-PLAY with remaining = 2 for 4 beats -> no decrement and no pulse; on resume, 2 more beats are needed; drop during LOAD defers the pulse.
- song_select 0 -> 2 mid-note -> next rom_addr = 7'b10_00000, song_done 0, new pulse 2 cycles later; a change while in DONE also restarts.
- All 32 entries with duration 1 and no marker -> 32 pulses, then song_done = 1 with index 31 (no wrap to 0).
- Assert reset mid-PLAY -> all outputs return to reset values immediately (asynchronous), no pulse until play_enable is reasserted.
